snake_body_store: RTL and testbench

Holds the snake's segment coordinates on the 124×81 block grid and advances the snake one block per `move_tick`. The snake advances in the commanded direction, grows on request, and flags wall and self collisions. It sits directly upstream of the graphic stage. While idle it streams one segment per clock as (`body_count`, `snake_body_x`, `snake_body_y`), so the graphic stage can rebuild its segment array, and it also drives `snake_head_x/y` and `snake_length`.

---
 rtl/snake_body_store.sv | 153 +++++++++++++++
 tb/tb_snake_body_store.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_store.sv
// Segment store for the snake: advances the body one block per move_tick, grows on
// request, flags wall/self collisions, and streams one segment per idle clock.
module snake_body_store #(
   parameter int SNAKE_LENGTH_BIT = 4,
   parameter int SNAKE_LENGTH_MAX = 16,
   parameter int GRID_W           = 124,
   parameter int GRID_H           = 81,
   parameter int INIT_X           = 62,
   parameter int INIT_Y           = 40,
   parameter int INIT_LENGTH      = 3
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic                        move_tick,
   input  logic [1:0]                  direction,
   input  logic                        grow,
   output logic [6:0]                  snake_head_x,
   output logic [6:0]                  snake_head_y,
   output logic [6:0]                  snake_body_x,
   output logic [6:0]                  snake_body_y,
   output logic [SNAKE_LENGTH_BIT-1:0] body_count,
   output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   output logic                        busy,
   output logic                        update_done,
   output logic                        collision
);
   localparam int LB = SNAKE_LENGTH_BIT;
   // Length is LB bits wide, so growth stops at the largest representable count.
   localparam logic [LB-1:0] LEN_SAT = '1;

   typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_HEAD, S_CHECK, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [6:0]      r_mem_x [SNAKE_LENGTH_MAX];
   logic [6:0]      r_mem_y [SNAKE_LENGTH_MAX];
   logic [1:0]      r_heading;
   logic [LB-1:0]   r_len, r_newlen, r_idx, r_body_count;
   logic [6:0]      r_head_x, r_head_y, r_cand_x, r_cand_y, r_body_x, r_body_y;
   logic            r_coll, r_grow_pend;

   logic [1:0]      w_dir;
   logic            w_wall, w_start, w_grow;
   logic [6:0]      w_cand_x, w_cand_y;
   logic [LB-1:0]   w_newlen, w_cnt_nxt;

   assign w_start   = (r_state == S_IDLE) && move_tick && !r_coll;
   assign w_grow    = r_grow_pend | grow;
   assign w_cnt_nxt = r_body_count + 1'b1;

   // Reversal keeps the current heading; wall test precedes arithmetic to avoid wrap.
   always_comb begin
      w_dir    = (direction == (r_heading ^ 2'b10)) ? r_heading : direction;
      w_wall   = 1'b0;
      w_cand_x = r_head_x;
      w_cand_y = r_head_y;
      case (w_dir)
         2'b00: if (r_head_y == 7'd0) w_wall = 1'b1; else w_cand_y = r_head_y - 7'd1;
         2'b01: if (r_head_x == 7'(GRID_W - 1)) w_wall = 1'b1; else w_cand_x = r_head_x + 7'd1;
         2'b10: if (r_head_y == 7'(GRID_H - 1)) w_wall = 1'b1; else w_cand_y = r_head_y + 7'd1;
         default: if (r_head_x == 7'd0) w_wall = 1'b1; else w_cand_x = r_head_x - 7'd1;
      endcase
      w_newlen = (w_grow && (r_len != LEN_SAT)) ? r_len + 1'b1 : r_len;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = w_wall ? S_DONE : S_SHIFT;
         S_SHIFT: if (r_idx == LB'(1)) w_next = S_HEAD;
         S_HEAD:  w_next = S_CHECK;
         S_CHECK: if (r_idx == r_len - 1'b1) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_25) begin
      if (!reset) begin
         r_state <= S_IDLE;
         for (int k = 0; k < SNAKE_LENGTH_MAX; k++) begin
            r_mem_x[k] <= (k < INIT_LENGTH) ? 7'(INIT_X - k) : 7'h7F;
            r_mem_y[k] <= (k < INIT_LENGTH) ? 7'(INIT_Y)     : 7'h7F;
         end
         r_heading    <= 2'b01;
         r_len        <= LB'(INIT_LENGTH);
         r_newlen     <= LB'(INIT_LENGTH);
         r_idx        <= '0;
         r_head_x     <= 7'(INIT_X);
         r_head_y     <= 7'(INIT_Y);
         r_cand_x     <= 7'(INIT_X);
         r_cand_y     <= 7'(INIT_Y);
         r_body_count <= '0;
         r_body_x     <= 7'(INIT_X);
         r_body_y     <= 7'(INIT_Y);
         r_coll       <= 1'b0;
         r_grow_pend  <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_grow_pend <= r_grow_pend | grow;
         case (r_state)
            S_IDLE: begin
               // Data is fetched for the index being presented next, keeping them aligned.
               r_body_count <= w_cnt_nxt;
               r_body_x     <= r_mem_x[w_cnt_nxt];
               r_body_y     <= r_mem_y[w_cnt_nxt];
               if (w_start) begin
                  r_heading <= w_dir;
                  if (w_wall) begin
                     r_coll <= 1'b1;
                  end else begin
                     r_cand_x    <= w_cand_x;
                     r_cand_y    <= w_cand_y;
                     r_newlen    <= w_newlen;
                     r_idx       <= w_newlen - 1'b1;
                     r_grow_pend <= 1'b0;
                  end
               end
            end
            S_SHIFT: begin
               r_mem_x[r_idx] <= r_mem_x[r_idx - 1'b1];
               r_mem_y[r_idx] <= r_mem_y[r_idx - 1'b1];
               r_idx          <= r_idx - 1'b1;
            end
            S_HEAD: begin
               r_mem_x[0] <= r_cand_x;
               r_mem_y[0] <= r_cand_y;
               r_head_x   <= r_cand_x;
               r_head_y   <= r_cand_y;
               r_len      <= r_newlen;
               r_idx      <= LB'(1);
            end
            S_CHECK: begin
               if (r_mem_x[r_idx] == r_head_x && r_mem_y[r_idx] == r_head_y) r_coll <= 1'b1;
               r_idx <= r_idx + 1'b1;
            end
            default: begin
               // Refresh the frozen stream entry so it reflects the committed move.
               r_body_x <= r_mem_x[r_body_count];
               r_body_y <= r_mem_y[r_body_count];
            end
         endcase
      end
   end

   assign snake_head_x = r_head_x;
   assign snake_head_y = r_head_y;
   assign snake_body_x = r_body_x;
   assign snake_body_y = r_body_y;
   assign body_count   = r_body_count;
   assign snake_length = r_len;
   assign busy         = (r_state != S_IDLE);
   assign update_done  = (r_state == S_DONE);
   assign collision    = r_coll;
endmodule

// File: tb/tb_snake_body_store.sv
// Bench for snake_body_store: segment-list model checked every cycle plus
// hand-computed expectations for latency, heads and streamed bodies.
module tb_snake_body_store;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       move_tick = 1'b0;
   logic       grow = 1'b0;
   logic [1:0] direction = 2'b00;
   logic [6:0] head_x, head_y, body_x, body_y;
   logic [3:0] body_count, snake_length;
   logic       busy, update_done, collision;

   snake_body_store dut (
      .clock_25(clk), .reset(rst_n), .move_tick(move_tick), .direction(direction),
      .grow(grow), .snake_head_x(head_x), .snake_head_y(head_y),
      .snake_body_x(body_x), .snake_body_y(body_y), .body_count(body_count),
      .snake_length(snake_length), .busy(busy), .update_done(update_done),
      .collision(collision)
   );

   always #20 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: segment list (head first), remaining busy cycles, stream position.
   int m_x[16], m_y[16];
   int m_len, m_heading, m_coll, m_gp, m_left, m_count;

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_x[i] = (i < 3) ? 62 - i : 127;
         m_y[i] = (i < 3) ? 40 : 127;
      end
      m_len = 3; m_heading = 1; m_coll = 0; m_gp = 0; m_left = 0; m_count = 0;
   endtask

   always @(posedge clk) begin
      int hx, hy, nl;
      bit accepted;
      cyc++;
      if (!rst_n) begin
         m_reset();
      end else if (m_left > 0) begin
         m_left--;
         m_gp = m_gp | int'(grow);
      end else begin
         accepted = 1'b0;
         m_count = (m_count + 1) % 16;
         if (move_tick && m_coll == 0) begin
            if (int'(direction) != (m_heading + 2) % 4) m_heading = int'(direction);
            hx = m_x[0]; hy = m_y[0];
            case (m_heading)
               0: hy = hy - 1;
               1: hx = hx + 1;
               2: hy = hy + 1;
               default: hx = hx - 1;
            endcase
            if (hx < 0 || hx > 123 || hy < 0 || hy > 80) begin
               m_coll = 1; m_left = 1;
            end else begin
               accepted = 1'b1;
               nl = m_len + ((m_gp != 0 || grow) ? 1 : 0);
               if (nl > 15) nl = 15;
               for (int i = nl - 1; i >= 1; i--) begin
                  m_x[i] = m_x[i-1]; m_y[i] = m_y[i-1];
               end
               m_x[0] = hx; m_y[0] = hy;
               for (int i = 1; i < nl; i++)
                  if (m_x[i] == hx && m_y[i] == hy) m_coll = 1;
               m_len = nl; m_left = 2 * nl; m_gp = 0;
            end
         end
         if (!accepted) m_gp = m_gp | int'(grow);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", busy, (m_left > 0) ? 1 : 0);
         chk("update_done", update_done, (m_left == 1) ? 1 : 0);
         chk("body_count", body_count, m_count);
         if (m_left == 0) begin
            chk("body_x", body_x, m_x[m_count]);
            chk("body_y", body_y, m_y[m_count]);
            chk("head_x", head_x, m_x[0]);
            chk("head_y", head_y, m_y[0]);
            chk("length", snake_length, m_len);
            chk("collision", collision, m_coll);
         end else if (m_left == 1) begin
            chk("collision_done", collision, m_coll);
         end
      end
   end

   task automatic do_move(input logic [1:0] dir, input logic g, input int lat, input bit extra);
      int t;
      bit got;
      @(posedge clk); #1;
      move_tick = 1'b1; direction = dir; grow = g; t = cyc;
      @(posedge clk); #1;
      move_tick = 1'b0; grow = 1'b0;
      if (extra) begin
         repeat (2) @(posedge clk);
         #1 move_tick = 1'b1; direction = 2'b01;
         @(posedge clk); #1 move_tick = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (update_done) got = 1'b1;
      end
      chk("done_seen", got, 1);
      chk("latency", cyc - t, lat);
   endtask

   task automatic lit_stream(input int n, input int xs[5], input int ys[5]);
      bit found;
      for (int i = 0; i < n; i++) begin
         found = 1'b0;
         for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (!busy && body_count == 4'(i)) found = 1'b1;
         end
         chk("stream_found", found, 1);
         chk("stream_x", body_x, xs[i]);
         chk("stream_y", body_y, ys[i]);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic head_is(input int x, input int y, input int len, input int col);
      chk("lit_head_x", head_x, x);
      chk("lit_head_y", head_y, y);
      chk("lit_length", snake_length, len);
      chk("lit_collision", collision, col);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lx[5], ly[5];
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; chk_on = 1'b1;

      // Reset contents streamed over one full wrap.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("rst_count", body_count, i);
         chk("rst_body_x", body_x, (i < 3) ? 62 - i : 127);
         chk("rst_body_y", body_y, (i < 3) ? 40 : 127);
      end
      head_is(62, 40, 3, 0);
      chk("rst_busy", busy, 0);

      do_move(2'b01, 1'b0, 6, 1'b0);
      @(negedge clk); head_is(63, 40, 3, 0);
      lx = '{63, 62, 61, 0, 0}; ly = '{40, 40, 40, 0, 0};
      lit_stream(3, lx, ly);

      @(posedge clk); #1 grow = 1'b1;
      @(posedge clk); #1 grow = 1'b0;
      do_move(2'b10, 1'b0, 8, 1'b0);
      @(negedge clk); head_is(63, 41, 4, 0);
      lx = '{63, 63, 62, 61, 0}; ly = '{41, 40, 40, 40, 0};
      lit_stream(4, lx, ly);

      do_move(2'b00, 1'b0, 8, 1'b0);   // reversal of down
      @(negedge clk); head_is(63, 42, 4, 0);
      do_move(2'b01, 1'b0, 8, 1'b0);
      @(negedge clk); head_is(64, 42, 4, 0);
      do_move(2'b11, 1'b0, 8, 1'b0);   // reversal of right
      @(negedge clk); head_is(65, 42, 4, 0);

      do_move(2'b10, 1'b1, 10, 1'b0);  // grow in the tick cycle
      @(negedge clk); head_is(65, 43, 5, 0);
      do_move(2'b11, 1'b0, 10, 1'b0);
      @(negedge clk); head_is(64, 43, 5, 0);
      do_move(2'b00, 1'b0, 10, 1'b1);  // onto own body, extra tick while busy
      @(negedge clk); head_is(64, 42, 5, 1);
      lx = '{64, 64, 65, 65, 64}; ly = '{42, 43, 43, 42, 42};
      lit_stream(5, lx, ly);

      @(posedge clk); #1 move_tick = 1'b1; direction = 2'b01;
      @(posedge clk); #1 move_tick = 1'b0;
      repeat (12) @(negedge clk);
      head_is(64, 42, 5, 1);

      // Reset in the middle of a shift.
      do_reset();
      @(posedge clk); #1 move_tick = 1'b1; direction = 2'b01;
      @(posedge clk); #1 move_tick = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      head_is(62, 40, 3, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_count", body_count, 0);
      lx = '{62, 61, 60, 0, 0}; ly = '{40, 40, 40, 0, 0};
      lit_stream(3, lx, ly);

      // Right wall.
      for (int k = 0; k < 61; k++) do_move(2'b01, 1'b0, 6, 1'b0);
      @(negedge clk); head_is(123, 40, 3, 0);
      do_move(2'b01, 1'b0, 1, 1'b0);
      @(negedge clk); head_is(123, 40, 3, 1);
      lx = '{123, 122, 121, 0, 0}; ly = '{40, 40, 40, 0, 0};
      lit_stream(3, lx, ly);
      @(posedge clk); #1 move_tick = 1'b1; direction = 2'b10;
      @(posedge clk); #1 move_tick = 1'b0;
      repeat (10) @(negedge clk);
      head_is(123, 40, 3, 1);
      chk("post_wall_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
